// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared states, requester IDs and timeout default for mem_arbiter
package mem_arbiter_pkg;

    // Arbiter sequencing: sample requests, hold the memory access, pulse the response
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    // Requester identity of the access currently owned by the arbiter
    typedef logic arb_src_t;

    localparam arb_src_t ARB_SRC_L1I = 1'b0;
    localparam arb_src_t ARB_SRC_L1D = 1'b1;

    // Default number of ISSUE cycles to wait for mem_ack before aborting
    localparam int ARB_TIMEOUT_CYCLES_DEFAULT = 255;

    // Counter width able to hold the value TIMEOUT_CYCLES itself
    function automatic int arb_count_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - saturating ISSUE-cycle counter that flags an expired memory access
module arb_timeout_counter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = arb_count_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear on a new access, count unacknowledged ISSUE cycles, saturate instead of wrapping
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != COUNT_LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // This unacknowledged cycle is the TIMEOUT_CYCLES-th one; an ack in the same cycle masks it
    assign expired_o = enable_i && (count_q == COUNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (l1i/l1d) backing-memory arbiter; MEM_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  l1i_req,
    input  logic [ADDR_WIDTH-1:0] l1i_address,
    output logic                  l1i_ready,
    output logic [DATA_WIDTH-1:0] l1i_data,

    input  logic                  l1d_req,
    input  logic                  l1d_write,
    input  logic [ADDR_WIDTH-1:0] l1d_address,
    input  logic [DATA_WIDTH-1:0] l1d_wdata,
    output logic                  l1d_ready,
    output logic [DATA_WIDTH-1:0] l1d_data,

    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  bus_error
);

    arb_state_e            state_q;
    arb_src_t              src_q;
    arb_src_t              grant_d;
    logic                  any_req;
    logic                  timeout_clear;
    logic                  timeout_enable;
    logic                  timeout_expired;

    logic                  mem_valid_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  l1i_ready_q;
    logic                  l1d_ready_q;
    logic [DATA_WIDTH-1:0] l1i_data_q;
    logic [DATA_WIDTH-1:0] l1d_data_q;
    logic                  bus_error_q;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    arb_src_t              last_grant_q;
`endif

    assign any_req = l1i_req || l1d_req;

    // Pick the winner among requests pending in IDLE
    always_comb begin
        grant_d = l1d_req ? ARB_SRC_L1D : ARB_SRC_L1I;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (l1i_req && l1d_req) begin
            grant_d = (last_grant_q == ARB_SRC_L1I) ? ARB_SRC_L1D : ARB_SRC_L1I;
        end
`endif
    end

    // The timer restarts with every accepted access and runs only while ISSUE waits for an ack
    assign timeout_clear  = (state_q == ARB_IDLE) && any_req;
    assign timeout_enable = (state_q == ARB_ISSUE) && !mem_ack;

    arb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .clear_i   (timeout_clear),
        .enable_i  (timeout_enable),
        .expired_o (timeout_expired)
    );

    // Arbiter FSM with registered memory request and requester responses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            src_q         <= ARB_SRC_L1I;
            mem_valid_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            l1i_ready_q   <= 1'b0;
            l1d_ready_q   <= 1'b0;
            l1i_data_q    <= '0;
            l1d_data_q    <= '0;
            bus_error_q   <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q  <= ARB_SRC_L1I;
`endif
        end else begin
            l1i_ready_q <= 1'b0;
            l1d_ready_q <= 1'b0;
            bus_error_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        src_q       <= grant_d;
                        mem_valid_q <= 1'b1;
                        state_q     <= ARB_ISSUE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_grant_q <= grant_d;
`endif
                        if (grant_d == ARB_SRC_L1D) begin
                            mem_write_q   <= l1d_write;
                            mem_address_q <= l1d_address;
                            mem_wdata_q   <= l1d_write ? l1d_wdata : '0;
                        end else begin
                            mem_write_q   <= 1'b0;
                            mem_address_q <= l1i_address;
                            mem_wdata_q   <= '0;
                        end
                    end
                end
                ARB_ISSUE: begin
                    if (mem_ack) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= ARB_RESP;
                        if (src_q == ARB_SRC_L1D) begin
                            l1d_ready_q <= 1'b1;
                            l1d_data_q  <= mem_write_q ? '0 : mem_rdata;
                        end else begin
                            l1i_ready_q <= 1'b1;
                            l1i_data_q  <= mem_rdata;
                        end
                    end else if (timeout_expired) begin
                        mem_valid_q <= 1'b0;
                        bus_error_q <= 1'b1;
                        state_q     <= ARB_RESP;
                        if (src_q == ARB_SRC_L1D) begin
                            l1d_ready_q <= 1'b1;
                            l1d_data_q  <= '0;
                        end else begin
                            l1i_ready_q <= 1'b1;
                            l1i_data_q  <= '0;
                        end
                    end
                end
                ARB_RESP: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_valid   = mem_valid_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign l1i_ready   = l1i_ready_q;
    assign l1i_data    = l1i_data_q;
    assign l1d_ready   = l1d_ready_q;
    assign l1d_data    = l1d_data_q;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter against a transaction model
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          l1i_req = 1'b0;
    logic [AW-1:0] l1i_address = '0;
    logic          l1i_ready;
    logic [DW-1:0] l1i_data;
    logic          l1d_req = 1'b0;
    logic          l1d_write = 1'b0;
    logic [AW-1:0] l1d_address = '0;
    logic [DW-1:0] l1d_wdata = '0;
    logic          l1d_ready;
    logic [DW-1:0] l1d_data;
    logic          mem_valid;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          bus_error;

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .l1i_req     (l1i_req),
        .l1i_address (l1i_address),
        .l1i_ready   (l1i_ready),
        .l1i_data    (l1i_data),
        .l1d_req     (l1d_req),
        .l1d_write   (l1d_write),
        .l1d_address (l1d_address),
        .l1d_wdata   (l1d_wdata),
        .l1d_ready   (l1d_ready),
        .l1d_data    (l1d_data),
        .mem_valid   (mem_valid),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .bus_error   (bus_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction model: one access in flight, counted in ISSUE cycles
    bit            m_active, m_resp, m_src_d, m_write, m_last_d;
    int            m_wait;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            e_i_ready, e_d_ready, e_berr;
    logic [DW-1:0] e_i_data, e_d_data;

    // Stimulus state
    int            m_delay;
    int            fixed_delay = -1;
    bit            fixed_data_en = 1'b0;
    logic [DW-1:0] fixed_data = '0;
    bit            spur_en = 1'b0;
    bit            i_drop, d_drop, i_drop_now, d_drop_now;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_resp = 0; m_wait = 0; m_last_d = 0; m_src_d = 0;
        e_i_ready = 0; e_d_ready = 0; e_berr = 0;
        e_i_data = '0; e_d_data = '0;
    endtask

    task automatic model_finish(input bit err, input logic [DW-1:0] rdata);
        m_active = 0;
        m_resp   = 1;
        e_berr   = err;
        if (m_src_d) begin
            e_d_ready = 1;
            e_d_data  = (err || m_write) ? '0 : rdata;
        end else begin
            e_i_ready = 1;
            e_i_data  = err ? '0 : rdata;
        end
    endtask

    // Apply the arbiter rules to the inputs present at the coming rising edge
    task automatic model_edge();
        bit take_d;
        e_i_ready = 0; e_d_ready = 0; e_berr = 0;
        if (m_resp) begin
            m_resp = 0;
        end else if (m_active) begin
            if (mem_ack) model_finish(1'b0, mem_rdata);
            else if (m_wait + 1 >= TO) model_finish(1'b1, '0);
            else m_wait++;
        end else if (l1i_req || l1d_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            take_d = l1d_req && (!l1i_req || !m_last_d);
`else
            take_d = l1d_req;
`endif
            m_last_d = take_d;
            m_src_d  = take_d;
            m_active = 1;
            m_wait   = 0;
            m_write  = take_d ? l1d_write : 1'b0;
            m_addr   = take_d ? l1d_address : l1i_address;
            m_wdata  = l1d_wdata;
        end
    endtask

    task automatic check_all();
        chk("mem_valid", mem_valid, m_active);
        chk("l1i_ready", l1i_ready, e_i_ready);
        chk("l1d_ready", l1d_ready, e_d_ready);
        chk("bus_error", bus_error, e_berr);
        chk("l1i_data", l1i_data, e_i_data);
        chk("l1d_data", l1d_data, e_d_data);
        if (m_active) begin
            chk("mem_address", mem_address, m_addr);
            chk("mem_write", mem_write, m_write);
            if (m_write) chk("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    // One clock: edge, compare, then requesters and memory react
    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
        i_drop_now = 0; d_drop_now = 0;
        if (i_drop) begin l1i_req = 0; i_drop = 0; i_drop_now = 1; end
        if (d_drop) begin l1d_req = 0; d_drop = 0; d_drop_now = 1; end
        if (e_i_ready) i_drop = 1;
        if (e_d_ready) d_drop = 1;
        if (m_active && m_wait == 0)
            m_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 5));
        if (m_active) mem_ack = (m_wait == m_delay);
        else mem_ack = spur_en && ($urandom_range(0, 3) == 0);
        mem_rdata = fixed_data_en ? fixed_data : DW'($urandom);
    endtask

    task automatic run_until_idle(input string name, input int max);
        int n = 0;
        while ((m_active || m_resp) && n < max) begin
            cycle();
            n++;
        end
        n_tests++;
        if (m_active || m_resp) begin
            n_fail++;
            $display("FAIL %s: access still busy after %0d cycles", name, max);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] first_addr;
        logic [AW-1:0] second_addr;

        model_reset();
        i_drop = 0; d_drop = 0;
        repeat (2) @(posedge clock);
        #1;
        check_all();
        chk("reset_mem_valid", mem_valid, 1'b0);
        chk("reset_l1d_data", l1d_data, 32'h0);

        // First request right after reset release, ack in the third ISSUE cycle
        reset_n = 1; fixed_data_en = 1; fixed_data = 32'hDEADBEEF; fixed_delay = 2;
        l1i_req = 1; l1i_address = 32'h10;
        cycle();
        chk("first_accept_valid", mem_valid, 1'b1);
        chk("first_accept_addr", mem_address, 32'h10);
        cycle(); cycle();
        cycle();
        chk("rd_l1i_ready", l1i_ready, 1'b1);
        chk("rd_l1i_data", l1i_data, 32'hDEADBEEF);
        chk("rd_bus_error", bus_error, 1'b0);
        chk("rd_l1d_ready_low", l1d_ready, 1'b0);
        cycle();
        chk("rd_ready_one_cycle", l1i_ready, 1'b0);
        run_until_idle("rd_done", 10);

        // l1d write with payload held through ISSUE
        fixed_data = 32'h5555AAAA;
        l1d_req = 1; l1d_write = 1; l1d_address = 32'h40; l1d_wdata = 32'hCAFE0001;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("wr_mem_write", mem_write, 1'b1);
            chk("wr_mem_addr", mem_address, 32'h40);
            chk("wr_mem_wdata", mem_wdata, 32'hCAFE0001);
        end
        cycle();
        chk("wr_l1d_ready", l1d_ready, 1'b1);
        chk("wr_l1d_data", l1d_data, 32'h0);
        run_until_idle("wr_done", 10);
        cycle();

        // Contested request, last grant was l1d
        fixed_delay = 0; fixed_data = 32'h0BADF00D;
        l1d_req = 1; l1d_write = 0; l1d_address = 32'h20;
        l1i_req = 1; l1i_address = 32'h30;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        first_addr = 32'h30; second_addr = 32'h20;
`else
        first_addr = 32'h20; second_addr = 32'h30;
`endif
        cycle();
        chk("contest_first", mem_address, first_addr);
        run_until_idle("contest_first_done", 10);
        cycle();
        chk("contest_second", mem_address, second_addr);
        run_until_idle("contest_second_done", 10);
        cycle();

        // No ack at all: abort after TO ISSUE cycles
        fixed_delay = 99;
        l1i_req = 1; l1i_address = 32'h50;
        for (int k = 0; k < TO; k++) begin
            cycle();
            chk("to_mem_valid", mem_valid, 1'b1);
        end
        cycle();
        chk("to_mem_valid_drop", mem_valid, 1'b0);
        chk("to_l1i_ready", l1i_ready, 1'b1);
        chk("to_bus_error", bus_error, 1'b1);
        chk("to_l1i_data", l1i_data, 32'h0);
        run_until_idle("to_done", 10);
        cycle();

        // Ack in the same cycle the timeout would fire
        fixed_delay = TO - 1; fixed_data = 32'h12345678;
        l1d_req = 1; l1d_write = 0; l1d_address = 32'h60;
        repeat (TO) cycle();
        cycle();
        chk("race_l1d_ready", l1d_ready, 1'b1);
        chk("race_l1d_data", l1d_data, 32'h12345678);
        chk("race_bus_error", bus_error, 1'b0);
        run_until_idle("race_done", 10);
        cycle();

        // Reset in the middle of ISSUE
        fixed_delay = 99;
        l1i_req = 1; l1i_address = 32'h80;
        cycle(); cycle();
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("rst_mem_valid_async", mem_valid, 1'b0);
        check_all();
        l1i_req = 0; i_drop = 0; d_drop = 0; mem_ack = 0;
        @(posedge clock);
        #1;
        check_all();
        reset_n = 1;
        fixed_delay = 1; fixed_data = 32'hA5A55A5A;
        l1d_req = 1; l1d_write = 0; l1d_address = 32'h70;
        cycle();
        chk("rst_after_addr", mem_address, 32'h70);
        cycle();
        cycle();
        chk("rst_after_ready", l1d_ready, 1'b1);
        chk("rst_after_data", l1d_data, 32'hA5A55A5A);
        run_until_idle("rst_after_done", 10);

        // Randomized traffic with spurious acks outside ISSUE
        fixed_delay = -1; fixed_data_en = 0; spur_en = 1;
        for (int k = 0; k < 3000; k++) begin
            cycle();
            if (!l1i_req && !i_drop_now && $urandom_range(0, 2) == 0) begin
                l1i_req = 1;
                l1i_address = AW'($urandom);
            end
            if (!l1d_req && !d_drop_now && $urandom_range(0, 2) == 0) begin
                l1d_req = 1;
                l1d_write = 1'($urandom_range(0, 1));
                l1d_address = AW'($urandom);
                l1d_wdata = DW'($urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
